// File: rtl/sisc_pkg.sv
// sisc_pkg: constants and helpers shared by the multi-cycle controller.
//   - FSM state encoding (3 bits, visible on ctrl_mc.state)
//   - opcode values of the instruction set
//   - addressing-mode constant AM_IMM and datapath select codes
//   - helpers for classifying memory opcodes and choosing the address path
package sisc_pkg;

    // Controller states
    localparam logic [2:0] ST_START     = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_MEM       = 3'd4;
    localparam logic [2:0] ST_WAIT      = 3'd5;
    localparam logic [2:0] ST_WRITEBACK = 3'd6;
    localparam logic [2:0] ST_HALT      = 3'd7;

    // Opcodes
    localparam int OP_NOOP = 0;
    localparam int OP_LOD  = 1;
    localparam int OP_STR  = 2;
    localparam int OP_SWP  = 3;
    localparam int OP_BRA  = 4;
    localparam int OP_BRR  = 5;
    localparam int OP_BNE  = 6;
    localparam int OP_BNR  = 7;
    localparam int OP_ALU  = 8;
    localparam int OP_HLT  = 15;

    // Immediate addressing mode
    localparam int AM_IMM = 8;

    // Load/store addressing modes carried in the mm field
    localparam int AM_DIRECT   = 0;
    localparam int AM_INDIRECT = 1;
    localparam int AM_INDEXED  = 9;

    // ALU operation selects
    localparam logic [1:0] ALU_DEFAULT = 2'b10;
    localparam logic [1:0] ALU_ALT     = 2'b11;

    // Memory-address operand selects
    localparam logic [1:0] MM_SEL_REG = 2'd0;
    localparam logic [1:0] MM_SEL_IMM = 2'd1;
    localparam logic [1:0] MM_SEL_IND = 2'd2;

    // Register-file read-address selects
    localparam logic [1:0] RD_SEL_IR  = 2'd0;
    localparam logic [1:0] RD_SEL_DEF = 2'd1;

    // Swap/auto-update register selects
    localparam logic [1:0] SWAP_SEL_NONE = 2'd0;
    localparam logic [1:0] SWAP_SEL_UPD  = 2'd2;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] mm_sel;
    } addr_sel_t;

    function automatic logic is_mem_op(input int op);
        return (op == OP_LOD) || (op == OP_STR);
    endfunction

    // Address computation path for a load/store given its mode field;
    // unrecognised modes fall back to the plain ALU path.
    function automatic addr_sel_t mem_addr_sel(input int mode);
        addr_sel_t sel;
        sel.alu_op = ALU_DEFAULT;
        sel.mm_sel = MM_SEL_REG;
        case (mode)
            AM_DIRECT: begin
                sel.alu_op = ALU_DEFAULT;
                sel.mm_sel = MM_SEL_IMM;
            end
            AM_INDIRECT: begin
                sel.alu_op = ALU_ALT;
                sel.mm_sel = MM_SEL_IND;
            end
            AM_INDEXED: begin
                sel.alu_op = ALU_ALT;
                sel.mm_sel = MM_SEL_REG;
            end
            default: ;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_mc_dec.sv
// ctrl_mc_dec: combinational datapath strobe/select decode for ctrl_mc.
// Inputs : state (3b), opcode (OPW), mm (STW), stat (STW)
// Outputs: rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load,
//          dm_we, dm_re, switch (1b each);
//          alu_op, rd_sel, mm_sel, swap_reg_sel (2b each)
module ctrl_mc_dec
    import sisc_pkg::*;
#(
    parameter int OPW = 4,
    parameter int STW = 4
) (
    input  logic [2:0]     state,
    input  logic [OPW-1:0] opcode,
    input  logic [STW-1:0] mm,
    input  logic [STW-1:0] stat,
    output logic           rf_we,
    output logic           wb_sel,
    output logic           br_sel,
    output logic           pc_rst,
    output logic           pc_write,
    output logic           pc_sel,
    output logic           ir_load,
    output logic           dm_we,
    output logic           dm_re,
    output logic           switch,
    output logic [1:0]     alu_op,
    output logic [1:0]     rd_sel,
    output logic [1:0]     mm_sel,
    output logic [1:0]     swap_reg_sel
);

    int        op_v;
    int        mm_v;
    logic      mm_zero;
    logic      stat_hit;
    logic      mem_op;
    addr_sel_t addr;
    logic [1:0] exec_alu;
    logic [1:0] exec_mm_sel;

    assign op_v     = int'(opcode);
    assign mm_v     = int'(mm);
    assign mm_zero  = (mm == '0);
    assign stat_hit = ((stat & mm) != '0);
    assign mem_op   = is_mem_op(op_v);
    assign addr     = mem_addr_sel(mm_v);

    // ALU/address selection chosen in EXECUTE; MEM and WAIT keep it stable
    // so the address presented to data memory does not move mid-access.
    always_comb begin
        exec_alu    = ALU_DEFAULT;
        exec_mm_sel = MM_SEL_REG;
        if (op_v == OP_ALU) begin
            exec_alu = {1'b0, mm_v == AM_IMM};
        end else if (op_v == OP_SWP) begin
            exec_alu = ALU_ALT;
        end else if (mem_op) begin
            exec_alu    = addr.alu_op;
            exec_mm_sel = addr.mm_sel;
        end
    end

    always_comb begin
        rf_we        = 1'b0;
        wb_sel       = 1'b1;
        br_sel       = 1'b0;
        pc_rst       = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b1;
        ir_load      = 1'b0;
        dm_we        = 1'b0;
        dm_re        = 1'b0;
        switch       = 1'b0;
        alu_op       = ALU_DEFAULT;
        rd_sel       = RD_SEL_DEF;
        mm_sel       = MM_SEL_REG;
        swap_reg_sel = SWAP_SEL_NONE;

        case (state)
            ST_START: pc_rst = 1'b1;

            ST_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                pc_sel   = 1'b0;
            end

            // Branches resolve here: a zero mask means unconditional,
            // otherwise BRA/BRR test for any masked status bit set and
            // BNE/BNR for all masked status bits clear.
            ST_DECODE: begin
                if (op_v == OP_BRA || op_v == OP_BNE)
                    br_sel = 1'b1;
                if (op_v == OP_LOD || op_v == OP_SWP)
                    rd_sel = RD_SEL_IR;
                if ((op_v == OP_BRA || op_v == OP_BRR) && (mm_zero || stat_hit))
                    pc_write = 1'b1;
                if ((op_v == OP_BNE || op_v == OP_BNR) && (mm_zero || !stat_hit))
                    pc_write = 1'b1;
            end

            ST_EXECUTE: begin
                alu_op = exec_alu;
                mm_sel = exec_mm_sel;
                if (op_v == OP_SWP)
                    switch = 1'b1;
            end

            ST_MEM, ST_WAIT: begin
                alu_op = exec_alu;
                mm_sel = exec_mm_sel;
                if (op_v == OP_STR) begin
                    dm_we  = 1'b1;
                    rd_sel = RD_SEL_IR;
                end else if (op_v == OP_LOD) begin
                    dm_re = 1'b1;
                end
            end

            // Indirect and indexed loads/stores also write the updated
            // pointer back, which takes the ALU result path (wb_sel=1)
            // even for a load.
            ST_WRITEBACK: begin
                if (op_v == OP_ALU || op_v == OP_LOD || op_v == OP_SWP)
                    rf_we = 1'b1;
                if (op_v == OP_LOD)
                    wb_sel = 1'b0;
                if (op_v == OP_SWP)
                    swap_reg_sel = SWAP_SEL_UPD;
                if (mem_op && (mm_v == AM_INDIRECT || mm_v == AM_INDEXED)) begin
                    swap_reg_sel = SWAP_SEL_UPD;
                    rf_we        = 1'b1;
                    wb_sel       = 1'b1;
                end
            end

            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_mc.sv
// ctrl_mc: multi-cycle instruction controller.
// Parameters: OPW opcode width, STW mask/status width, CNTW retired counter
//             width, TMO data-memory acknowledge timeout, FAST_PATH skip MEM
//             for non-memory instructions.
// Inputs : clk, rst (async, active-high), opcode, mm, stat, dm_ack, run
// Outputs: datapath strobes/selects (from ctrl_mc_dec), halted, mem_err,
//          state (3b), retired (CNTW)
module ctrl_mc
    import sisc_pkg::*;
#(
    parameter int OPW       = 4,
    parameter int STW       = 4,
    parameter int CNTW      = 16,
    parameter int TMO       = 8,
    parameter int FAST_PATH = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic [STW-1:0]  mm,
    input  logic [STW-1:0]  stat,
    input  logic            dm_ack,
    input  logic            run,
    output logic            rf_we,
    output logic            wb_sel,
    output logic            br_sel,
    output logic            pc_rst,
    output logic            pc_write,
    output logic            pc_sel,
    output logic            ir_load,
    output logic            dm_we,
    output logic            dm_re,
    output logic            switch,
    output logic [1:0]      alu_op,
    output logic [1:0]      rd_sel,
    output logic [1:0]      mm_sel,
    output logic [1:0]      swap_reg_sel,
    output logic            halted,
    output logic            mem_err,
    output logic [2:0]      state,
    output logic [CNTW-1:0] retired
);

    localparam int WCW = (TMO > 1) ? $clog2(TMO) : 1;

    logic [2:0]     state_q;
    logic [2:0]     state_d;
    logic           rst_done;
    logic [WCW-1:0] wait_cnt;
    logic           mem_op;
    logic           timeout;

    assign state   = state_q;
    assign mem_op  = is_mem_op(int'(opcode));
    // wait_cnt holds the number of WAIT cycles already spent, so the last
    // permitted WAIT cycle is the one where it reads TMO-1.
    assign timeout = (state_q == ST_WAIT) && !dm_ack && (wait_cnt == WCW'(TMO - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START:     if (rst_done) state_d = ST_FETCH;
            ST_FETCH:     state_d = ST_DECODE;
            ST_DECODE:    state_d = (opcode == OPW'(OP_HLT)) ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_d = (mem_op || FAST_PATH == 0) ? ST_MEM : ST_WRITEBACK;
            ST_MEM:       state_d = (mem_op && !dm_ack) ? ST_WAIT : ST_WRITEBACK;
            ST_WAIT: begin
                if (dm_ack)
                    state_d = ST_WRITEBACK;
                else if (timeout)
                    state_d = ST_HALT;
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_HALT:      if (run) state_d = ST_FETCH;
            default:      state_d = ST_START;
        endcase
    end

    // START is held for one extra cycle after reset release so the first
    // FETCH lands on the second rising edge; rst_done marks that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_START;
            rst_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            rst_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state_q == ST_WAIT)
            wait_cnt <= wait_cnt + WCW'(1);
        else
            wait_cnt <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired <= '0;
        else if (state_q == ST_WRITEBACK)
            retired <= retired + CNTW'(1);
    end

    // mem_err survives until the operator resumes with run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted  <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            halted <= (state_d == ST_HALT);
            if (timeout)
                mem_err <= 1'b1;
            else if (state_q == ST_HALT && run)
                mem_err <= 1'b0;
        end
    end

    ctrl_mc_dec #(
        .OPW(OPW),
        .STW(STW)
    ) u_dec (
        .state        (state_q),
        .opcode       (opcode),
        .mm           (mm),
        .stat         (stat),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .br_sel       (br_sel),
        .pc_rst       (pc_rst),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .ir_load      (ir_load),
        .dm_we        (dm_we),
        .dm_re        (dm_re),
        .switch       (switch),
        .alu_op       (alu_op),
        .rd_sel       (rd_sel),
        .mm_sel       (mm_sel),
        .swap_reg_sel (swap_reg_sel)
    );

endmodule

// File: tb/tb_ctrl_mc.sv
// tb_ctrl_mc: scoreboard bench for ctrl_mc. A driver issues one input set
// per cycle and queues the response predicted by a behavioural model; a
// monitor on the falling edge pops and compares against the DUT.
module tb_ctrl_mc;

    localparam int OPW  = 4;
    localparam int STW  = 4;
    localparam int CNTW = 4;
    localparam int TMO  = 8;
    localparam int FAST = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [OPW-1:0]  opcode;
    logic [STW-1:0]  mm;
    logic [STW-1:0]  stat;
    logic            dm_ack;
    logic            run;
    logic            rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel;
    logic            ir_load, dm_we, dm_re, switch;
    logic [1:0]      alu_op, rd_sel, mm_sel, swap_reg_sel;
    logic            halted, mem_err;
    logic [2:0]      state;
    logic [CNTW-1:0] retired;

    ctrl_mc #(
        .OPW(OPW), .STW(STW), .CNTW(CNTW), .TMO(TMO), .FAST_PATH(FAST)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mm(mm), .stat(stat),
        .dm_ack(dm_ack), .run(run),
        .rf_we(rf_we), .wb_sel(wb_sel), .br_sel(br_sel), .pc_rst(pc_rst),
        .pc_write(pc_write), .pc_sel(pc_sel), .ir_load(ir_load),
        .dm_we(dm_we), .dm_re(dm_re), .switch(switch),
        .alu_op(alu_op), .rd_sel(rd_sel), .mm_sel(mm_sel),
        .swap_reg_sel(swap_reg_sel),
        .halted(halted), .mem_err(mem_err), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int state, retired, halted, mem_err;
        int rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load;
        int dm_we, dm_re, sw, alu_op, rd_sel, mm_sel, swap;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: phase number, retired count, error flag, and how
    // many WAIT cycles / post-reset START cycles have elapsed.
    int m_state, m_retired, m_wait_cycles, m_start_cycles;
    int m_err;

    // Inputs currently applied to the DUT
    int c_rst, c_op, c_mm, c_stat, c_ack, c_run;

    int op_pool[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 15, 9, 12};
    int mm_pool[5]  = '{0, 1, 8, 9, 5};
    int ack_pool[5] = '{0, 1, 2, 5, 99};

    task automatic checkOutput(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        int   is_mem;
        int   ex_alu, ex_sel;
        int   set_hit, clr_hit;
        is_mem = (c_op == 1 || c_op == 2) ? 1 : 0;

        // address/ALU choice made in EXECUTE for each instruction kind
        ex_alu = 2; ex_sel = 0;
        if (c_op == 8) ex_alu = (c_mm == 8) ? 1 : 0;
        else if (c_op == 3) ex_alu = 3;
        else if (is_mem == 1) begin
            if (c_mm == 0)      begin ex_alu = 2; ex_sel = 1; end
            else if (c_mm == 1) begin ex_alu = 3; ex_sel = 2; end
            else if (c_mm == 9) begin ex_alu = 3; ex_sel = 0; end
        end

        set_hit = (c_mm == 0 || (c_stat & c_mm) != 0) ? 1 : 0;
        clr_hit = (c_mm == 0 || (c_stat & c_mm) == 0) ? 1 : 0;

        e = '{default: 0};
        e.pc_sel = 1; e.wb_sel = 1; e.rd_sel = 1; e.alu_op = 2;
        e.state = m_state; e.retired = m_retired; e.mem_err = m_err;
        e.halted = (m_state == 7) ? 1 : 0;

        if (m_state == 0) e.pc_rst = 1;
        if (m_state == 1) begin e.ir_load = 1; e.pc_write = 1; e.pc_sel = 0; end
        if (m_state == 2) begin
            if (c_op == 4 || c_op == 6) e.br_sel = 1;
            if (c_op == 1 || c_op == 3) e.rd_sel = 0;
            if ((c_op == 4 || c_op == 5) && set_hit == 1) e.pc_write = 1;
            if ((c_op == 6 || c_op == 7) && clr_hit == 1) e.pc_write = 1;
        end
        if (m_state == 3) begin
            e.alu_op = ex_alu; e.mm_sel = ex_sel;
            if (c_op == 3) e.sw = 1;
        end
        if (m_state == 4 || m_state == 5) begin
            e.alu_op = ex_alu; e.mm_sel = ex_sel;
            if (c_op == 2) begin e.dm_we = 1; e.rd_sel = 0; end
            if (c_op == 1) e.dm_re = 1;
        end
        if (m_state == 6) begin
            if (c_op == 8 || c_op == 1 || c_op == 3) e.rf_we = 1;
            if (c_op == 1) e.wb_sel = 0;
            if (c_op == 3) e.swap = 2;
            if (is_mem == 1 && (c_mm == 1 || c_mm == 9)) begin
                e.swap = 2; e.rf_we = 1; e.wb_sel = 1;
            end
        end
        return e;
    endfunction

    task automatic modelReset();
        m_state = 0; m_retired = 0; m_wait_cycles = 0; m_start_cycles = 0; m_err = 0;
    endtask

    task automatic modelStep();
        int is_mem;
        is_mem = (c_op == 1 || c_op == 2) ? 1 : 0;
        if (c_rst != 0) begin
            modelReset();
        end else begin
            case (m_state)
                0: begin
                    m_start_cycles++;
                    if (m_start_cycles >= 2) m_state = 1;
                end
                1: m_state = 2;
                2: m_state = (c_op == 15) ? 7 : 3;
                3: m_state = (is_mem == 1 || FAST == 0) ? 4 : 6;
                4: begin
                    if (is_mem == 1 && c_ack == 0) begin
                        m_wait_cycles = 0;
                        m_state = 5;
                    end else m_state = 6;
                end
                5: begin
                    if (c_ack != 0) m_state = 6;
                    else begin
                        m_wait_cycles++;
                        if (m_wait_cycles >= TMO) begin m_state = 7; m_err = 1; end
                    end
                end
                6: begin
                    m_retired = (m_retired + 1) % (1 << CNTW);
                    m_state = 1;
                end
                default: begin
                    if (c_run != 0) begin m_state = 1; m_err = 0; end
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        modelStep();
    endtask

    task automatic applyStimulus(input int r, input int op, input int m, input int s,
                                 input int ack, input int rn);
        rst    = (r != 0);
        opcode = OPW'(op);
        mm     = STW'(m);
        stat   = STW'(s);
        dm_ack = (ack != 0);
        run    = (rn != 0);
        c_rst = r; c_op = op; c_mm = m; c_stat = s; c_ack = ack; c_run = rn;
        if (r != 0) modelReset();
        exp_q.push_back(expect_now());
    endtask

    // Runs one instruction until its WRITEBACK or its release from HALT.
    // ack_delay counts MEM/WAIT cycles before dm_ack rises; reset_at
    // pulses rst on that cycle index; halt_wait is HALT cycles before run.
    task automatic runInstr(input int op, input int m, input int s, input int ack_delay,
                            input int reset_at, input int halt_wait);
        int n, mc, hc, r, ack, rn, done;
        n = 0; mc = 0; hc = 0; done = 0;
        while (done == 0 && n < 80) begin
            tick();
            r   = (n == reset_at) ? 1 : 0;
            ack = $urandom_range(0, 1);
            if (m_state == 4 || m_state == 5) begin
                ack = (mc >= ack_delay) ? 1 : 0;
                mc++;
            end
            rn = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if (m_state == 7) begin
                rn = (hc >= halt_wait) ? 1 : 0;
                hc++;
            end
            if (r == 0 && (m_state == 6 || (m_state == 7 && rn == 1))) done = 1;
            applyStimulus(r, op, m, s, ack, rn);
            n++;
        end
        if (done == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL instr_bound: opcode %0d did not complete, got state %0d, required completion", op, m_state);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("state",        int'(state),        e.state);
            checkOutput("retired",      int'(retired),      e.retired);
            checkOutput("halted",       int'(halted),       e.halted);
            checkOutput("mem_err",      int'(mem_err),      e.mem_err);
            checkOutput("rf_we",        int'(rf_we),        e.rf_we);
            checkOutput("wb_sel",       int'(wb_sel),       e.wb_sel);
            checkOutput("br_sel",       int'(br_sel),       e.br_sel);
            checkOutput("pc_rst",       int'(pc_rst),       e.pc_rst);
            checkOutput("pc_write",     int'(pc_write),     e.pc_write);
            checkOutput("pc_sel",       int'(pc_sel),       e.pc_sel);
            checkOutput("ir_load",      int'(ir_load),      e.ir_load);
            checkOutput("dm_we",        int'(dm_we),        e.dm_we);
            checkOutput("dm_re",        int'(dm_re),        e.dm_re);
            checkOutput("switch",       int'(switch),       e.sw);
            checkOutput("alu_op",       int'(alu_op),       e.alu_op);
            checkOutput("rd_sel",       int'(rd_sel),       e.rd_sel);
            checkOutput("mm_sel",       int'(mm_sel),       e.mm_sel);
            checkOutput("swap_reg_sel", int'(swap_reg_sel), e.swap);
        end
    end

    initial begin : watchdog
        #1000000;
        n_checks++;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : driver
        int op, m, ad, ra;
        rst = 1'b1; opcode = '0; mm = '0; stat = '0; dm_ack = 1'b0; run = 1'b0;
        c_rst = 1; c_op = 0; c_mm = 0; c_stat = 0; c_ack = 0; c_run = 0;
        modelReset();

        repeat (2) begin
            tick();
            applyStimulus(1, 0, 0, 0, 0, 1);
        end

        // ALU op from reset release, then a LOD with three WAIT cycles
        runInstr(8, 0, 0, 0, -1, 0);
        runInstr(1, 0, 0, 3, -1, 0);
        // store that never gets an acknowledge, resumed after a few cycles
        runInstr(2, 0, 0, 99, -1, 3);
        // conditional branch taken and not taken
        runInstr(4, 2, 2, 0, -1, 0);
        runInstr(4, 2, 0, 0, -1, 0);
        // halt instruction held for 20 cycles
        runInstr(15, 0, 0, 0, -1, 20);
        // retire enough to wrap the counter, then reset while in WAIT
        repeat (17) runInstr(8, 8, 0, 0, -1, 0);
        runInstr(1, 1, 0, 99, 5, 2);
        runInstr(2, 9, 0, 1, -1, 0);
        runInstr(3, 0, 0, 0, -1, 0);

        repeat (250) begin
            op = op_pool[$urandom_range(0, 11)];
            m  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : mm_pool[$urandom_range(0, 4)];
            ad = ack_pool[$urandom_range(0, 4)];
            ra = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 8)) : -1;
            runInstr(op, m, int'($urandom_range(0, 15)), ad, ra, int'($urandom_range(0, 4)));
        end

        @(negedge clk);
        #1;
        checkOutput("queue_drain", exp_q.size(), 0);
        $display("[TB] stimulus complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
